// File: rtl/regfile_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: default geometry
// (common with the register file itself) and the controller state encoding.
package regfile_write_sequencer_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  // Width of a binary index into n requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Requester handshake plus register-file write port of the write sequencer.
interface regfile_write_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        Req_Valid;
  logic [NUM_REQ*ADDR_W-1:0] Req_Register;
  logic [NUM_REQ*DATA_W-1:0] Req_Data;
  logic [NUM_REQ-1:0]        Req_Ready;
  logic [ADDR_W-1:0]         Write_Register;
  logic [DATA_W-1:0]         Write_Data;
  logic                      Reg_Write;
  logic                      Init_Busy;

  // The sequencer side.
  modport slave (
    input  Req_Valid, Req_Register, Req_Data,
    output Req_Ready, Write_Register, Write_Data, Reg_Write, Init_Busy
  );

  // Requesters and register file, as seen from outside the sequencer.
  modport master (
    output Req_Valid, Req_Register, Req_Data,
    input  Req_Ready, Write_Register, Write_Data, Reg_Write, Init_Busy
  );

endinterface

// File: rtl/regfile_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr
// (wrapping) wins; returns a one-hot grant and its binary index.
module rr_arbiter
  import regfile_write_sequencer_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   pos [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // hit[k] is the request sitting k places after the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign pos[gi] = IDX_W'((int'(ptr) + gi) % NUM_REQ);
      assign hit[gi] = req[pos[gi]];
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Scan from the far end so the closest requester is the last one kept.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) grant_idx = pos[k];
    end
    if (|hit) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register-file write-port controller: zero-fills every register after reset,
// then shares the port among requesters with round-robin valid/ready arbitration.
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input logic                  Clk,
  input logic                  Reset,
  regfile_write_sequencer_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e             state_reg, state_next;
  logic [ADDR_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [ADDR_W-1:0]  write_register_reg;
  logic [DATA_W-1:0]  write_data_reg;
  logic               reg_write_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               in_arb;
  logic               xfer;
  logic               init_last;
  logic [ADDR_W-1:0]  req_register [NUM_REQ];
  logic [DATA_W-1:0]  req_data     [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_register[gi] = bus.Req_Register[gi*ADDR_W +: ADDR_W];
      assign req_data[gi]     = bus.Req_Data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (bus.Req_Valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_arb        = (state_reg == ST_ARB);
  assign bus.Req_Ready = in_arb ? grant : '0;
  assign xfer          = |(bus.Req_Valid & bus.Req_Ready);
  assign init_last     = (cnt_reg == ADDR_W'(NUM_REGS - 1));

  assign bus.Init_Busy      = (state_reg == ST_INIT);
  assign bus.Write_Register = write_register_reg;
  assign bus.Write_Data     = write_data_reg;
  assign bus.Reg_Write      = reg_write_reg;

  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= ST_INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (init_last) state_next = ST_ARB;
      ST_ARB:  state_next = ST_ARB;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg            <= '0;
      ptr_reg            <= '0;
      write_register_reg <= '0;
      write_data_reg     <= '0;
      reg_write_reg      <= 1'b0;
    end else if (!in_arb) begin
      write_register_reg <= cnt_reg;
      write_data_reg     <= '0;
      reg_write_reg      <= 1'b1;
      cnt_reg            <= cnt_reg + 1'b1;
    end else if (xfer) begin
      write_register_reg <= req_register[grant_idx];
      write_data_reg     <= req_data[grant_idx];
      // Register 0 is hard-wired zero: the handshake completes, the write is dropped.
      reg_write_reg      <= (req_register[grant_idx] != '0);
      ptr_reg            <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      reg_write_reg      <= 1'b0;
    end
  end

endmodule
